// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encoding,
// per-digit BCD limits and the packed BCD value of the last displayable time.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  // Largest value a BCD digit may hold: decimal digits and tens-of-seconds.
  localparam int unsigned DIGIT_MAX_9 = 9;
  localparam int unsigned DIGIT_MAX_5 = 5;

  // 99:59.99 packed as {min_t, min_o, sec_t, sec_o, cs_t, cs_o}.
  localparam logic [23:0] TIME_MAX_BCD = 24'h995999;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit of the time cascade. Counts 0..MAX on inc and wraps to 0;
// carry is combinational so a whole cascade advances on a single edge.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = DIGIT_MAX_9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  localparam logic [3:0] MAX_DIGIT = 4'(MAX);

  // Digit register: synchronous clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order the simulator runs processes.
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= (digit == MAX_DIGIT) ? 4'd0 : digit + 4'd1;
    end
  end

  assign carry = inc & (digit == MAX_DIGIT);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/pause/lap/clear FSM, centisecond prescaler and a
// six-digit BCD time counter (MM:SS.cc) with lap-freeze display register.
// Optional build macro STOPWATCH_SATURATE_EN: hold at 99:59.99 instead of
// wrapping to 00:00.00 (overflow is flagged either way).
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ        = 100000000,
  parameter int TICK_HZ       = 100,
  parameter int PRESCALE_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop_pulse,
  input  logic       lap_reset_pulse,
  output logic       running,
  output logic       lap_active,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] cs_t,
  output logic [3:0] cs_o,
  output logic       overflow
);

  localparam int                       DIV           = CLK_HZ / TICK_HZ;
  localparam logic [PRESCALE_BITS-1:0] PRESCALE_LAST = PRESCALE_BITS'(DIV - 1);

  state_t                   state, state_next;
  logic                     clr, lap_capture;
  logic [PRESCALE_BITS-1:0] prescale;
  logic                     tick, tick_inc, at_max, overflow_set;

  logic [3:0] live_cs_o, live_cs_t, live_sec_o, live_sec_t, live_min_o, live_min_t;
  logic       c_cs_o, c_cs_t, c_sec_o, c_sec_t, c_min_o, c_min_t;
  logic [23:0] live_bcd, latched_bcd, shown_bcd;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; start_stop wins when both pulses arrive together.
  always_comb begin
    // NOTE: default assignment first so no path through this block leaves
    // state_next unassigned, which would infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (start_stop_pulse) state_next = RUN;
      RUN:     if (start_stop_pulse) state_next = PAUSE;
               else if (lap_reset_pulse) state_next = LAP;
      LAP:     if (start_stop_pulse) state_next = PAUSE;
               else if (lap_reset_pulse) state_next = RUN;
      PAUSE:   if (start_stop_pulse) state_next = RUN;
               else if (lap_reset_pulse) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: status flags, clear while entering/holding IDLE, lap capture.
  always_comb begin
    running     = (state == RUN) || (state == LAP);
    lap_active  = (state == LAP);
    clr         = (state_next == IDLE);
    lap_capture = (state == RUN) && (state_next == LAP);
  end

  // Prescaler: advances only while counting, holds in PAUSE to keep the
  // sub-tick phase across a resume, cleared only on the way into IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       prescale <= '0;
    else if (clr)     prescale <= '0;
    else if (running) prescale <= (prescale == PRESCALE_LAST) ? '0 : prescale + 1'b1;
  end

  assign tick     = running && (prescale == PRESCALE_LAST);
  assign live_bcd = {live_min_t, live_min_o, live_sec_t, live_sec_o, live_cs_t, live_cs_o};
  assign at_max   = (live_bcd == TIME_MAX_BCD);

`ifdef STOPWATCH_SATURATE_EN
  assign tick_inc = tick & ~at_max;
`else
  assign tick_inc = tick;
`endif

  // The final carry fires on a real wrap; the at_max term covers a tick that
  // saturation suppressed before it could reach the cascade.
  assign overflow_set = c_min_t | (tick & at_max);

  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_cs_o (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(tick_inc), .digit(live_cs_o), .carry(c_cs_o));
  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_cs_t (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(c_cs_o), .digit(live_cs_t), .carry(c_cs_t));
  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_sec_o (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(c_cs_t), .digit(live_sec_o), .carry(c_sec_o));
  bcd_digit_counter #(.MAX(DIGIT_MAX_5)) u_sec_t (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(c_sec_o), .digit(live_sec_t), .carry(c_sec_t));
  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_min_o (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(c_sec_t), .digit(live_min_o), .carry(c_min_o));
  bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_min_t (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(c_min_o), .digit(live_min_t), .carry(c_min_t));

  // Sticky overflow flag, released only by the return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (clr)          overflow <= 1'b0;
    else if (overflow_set) overflow <= 1'b1;
  end

  // Lap latch: snapshot of the live count taken on the RUN->LAP edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           latched_bcd <= '0;
    else if (clr)         latched_bcd <= '0;
    else if (lap_capture) latched_bcd <= live_bcd;
  end

  // Display register: frozen lap value while in LAP, live count otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shown_bcd <= '0;
    else        shown_bcd <= lap_active ? latched_bcd : live_bcd;
  end

  assign {min_t, min_o, sec_t, sec_o, cs_t, cs_o} = shown_bcd;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (CLK_HZ=1000, TICK_HZ=100, DIV=10) with a
// centisecond-integer reference model compared on every active cycle.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int DIV    = 10;
  localparam int MAX_CS = 599999;  // 99:59.99 in centiseconds
  localparam int MD_IDLE = 0, MD_RUN = 1, MD_PAUSE = 2, MD_LAP = 3;

  logic       clk, rst_n, ss, lr;
  logic       running, lap_active, overflow;
  logic [3:0] min_t, min_o, sec_t, sec_o, cs_t, cs_o;

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .PRESCALE_BITS(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_stop_pulse(ss), .lap_reset_pulse(lr),
    .running(running), .lap_active(lap_active),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .cs_t(cs_t), .cs_o(cs_o), .overflow(overflow));

  wire [23:0] dut_bcd   = {min_t, min_o, sec_t, sec_o, cs_t, cs_o};
  wire [2:0]  dut_flags = {running, lap_active, overflow};

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [23:0] to_bcd(input int c);
    int cs, s, m;
    cs = c % 100;
    s  = (c / 100) % 60;
    m  = c / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  // Reference model: time as a plain centisecond count, display one edge late.
  int          m_mode, m_phase, m_count, m_latch, m_old;
  bit          m_ovf, m_tick;
  logic [23:0] exp_bcd;
  logic [2:0]  exp_flags;
  bit          preload_req;
  int          preload_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = MD_IDLE; m_phase = 0; m_count = 0; m_latch = 0; m_ovf = 0;
      exp_bcd = '0; exp_flags = '0;
    end else begin
      if (preload_req) m_count = preload_val;
      exp_bcd = to_bcd((m_mode == MD_LAP) ? m_latch : m_count);
      m_tick = 0;
      if (m_mode == MD_RUN || m_mode == MD_LAP) begin
        if (m_phase == DIV - 1) begin m_phase = 0; m_tick = 1; end
        else m_phase++;
      end
      m_old = m_count;
      if (m_tick) begin
        if (m_count == MAX_CS) begin
          m_ovf = 1;
`ifndef STOPWATCH_SATURATE_EN
          m_count = 0;
`endif
        end else m_count++;
      end
      if (ss) begin
        case (m_mode)
          MD_IDLE, MD_PAUSE: m_mode = MD_RUN;
          default:           m_mode = MD_PAUSE;
        endcase
      end else if (lr) begin
        case (m_mode)
          MD_RUN:   begin m_mode = MD_LAP; m_latch = m_old; end
          MD_LAP:   m_mode = MD_RUN;
          MD_PAUSE: begin m_mode = MD_IDLE; m_phase = 0; m_count = 0; m_latch = 0; m_ovf = 0; end
          default:  ;
        endcase
      end
      exp_flags = {(m_mode == MD_RUN || m_mode == MD_LAP), (m_mode == MD_LAP), m_ovf};
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) check("cycle", {5'd0, dut_flags, dut_bcd}, {5'd0, exp_flags, exp_bcd});
  end

  task automatic pulse(input logic s, input logic l);
    ss = s; lr = l;
    @(negedge clk);
    ss = 1'b0; lr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ss = 1'b0; lr = 1'b0; preload_req = 0; preload_val = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("reset_state", {5'd0, dut_flags, dut_bcd}, 32'd0);

    // Start and run one second.
    pulse(1, 0);
    idle(1001);
    check("run_1s_disp", dut_bcd, 24'h000100);
    check("run_1s_flags", dut_flags, 3'b100);

    // Clear, run to 0.50, pause 200 clocks, resume 50 ticks.
    pulse(1, 0);
    pulse(0, 1);
    pulse(1, 0);
    idle(499);
    pulse(1, 0);
    idle(200);
    pulse(1, 0);
    idle(501);
    check("pause_resume_disp", dut_bcd, 24'h000100);

    // Lap freeze at 02.37, release after 300 clocks.
    idle(1369);
    pulse(0, 1);
    check("lap_hold_disp", dut_bcd, 24'h000237);
    check("lap_hold_flags", dut_flags, 3'b110);
    idle(300);
    check("lap_frozen_disp", dut_bcd, 24'h000237);
    pulse(0, 1);
    idle(1);
    check("lap_release_disp", dut_bcd, 24'h000267);
    check("lap_release_flags", dut_flags, 3'b100);

    // Simultaneous pulses in PAUSE: start_stop wins, count unchanged.
    pulse(1, 0);
    pulse(1, 1);
    check("both_disp", dut_bcd, 24'h000267);
    check("both_flags", dut_flags, 3'b100);
    pulse(1, 0);
    pulse(0, 1);
    idle(1);
    check("clear_disp", dut_bcd, 24'h000000);
    check("clear_flags", dut_flags, 3'b000);

    // Force 99:59.99 while paused, then resume into the rollover tick.
    pulse(1, 0);
    idle(3);
    pulse(1, 0);
    force dut.u_cs_o.digit  = 4'd9;
    force dut.u_cs_t.digit  = 4'd9;
    force dut.u_sec_o.digit = 4'd9;
    force dut.u_sec_t.digit = 4'd5;
    force dut.u_min_o.digit = 4'd9;
    force dut.u_min_t.digit = 4'd9;
    preload_val = MAX_CS;
    preload_req = 1;
    @(negedge clk);
    release dut.u_cs_o.digit;
    release dut.u_cs_t.digit;
    release dut.u_sec_o.digit;
    release dut.u_sec_t.digit;
    release dut.u_min_o.digit;
    release dut.u_min_t.digit;
    preload_req = 0;
    pulse(1, 0);
    idle(7);
`ifdef STOPWATCH_SATURATE_EN
    check("rollover_disp", dut_bcd, 24'h995999);
`else
    check("rollover_disp", dut_bcd, 24'h000000);
`endif
    check("rollover_flags", dut_flags, 3'b101);
    idle(100);
`ifdef STOPWATCH_SATURATE_EN
    check("after_rollover_disp", dut_bcd, 24'h995999);
`else
    check("after_rollover_disp", dut_bcd, 24'h000010);
`endif

    // Asynchronous reset between clock edges while running.
    #2 rst_n = 1'b0;
    #1 check("async_reset", {5'd0, dut_flags, dut_bcd}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    check("post_reset_idle", {5'd0, dut_flags, dut_bcd}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
